// File: rtl/keypad_scanner_fifo.sv
// Matrix keypad scanner: column drive, row debounce, key locking and a
// first-word-fall-through key-code FIFO drained with a valid/read handshake.
module keypad_scanner_fifo #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int SCAN_DIVIDER   = 50000,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int FIFO_DEPTH     = 4,
    localparam int CODE_WIDTH    = $clog2(NUM_ROWS * NUM_COLS),
    localparam int CNT_WIDTH     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    input  logic [NUM_ROWS-1:0]   Rows,
    output logic [NUM_COLS-1:0]   Columns,
    input  logic                  KeyRead,
    output logic                  KeyValid,
    output logic [CODE_WIDTH-1:0] KeyCode,
    output logic [CNT_WIDTH-1:0]  Count,
    output logic                  Found,
    output logic                  Locked,
    output logic                  Overflow
);

    localparam int PRE_W = $clog2(SCAN_DIVIDER);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

    state_e                state_q, state_d;
    logic [NUM_ROWS-1:0]   rows_meta_q, rows_sync_q;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [COL_W-1:0]      col_q, col_d, col_next;
    logic [ROW_W-1:0]      row_q, row_d, low_row;
    logic [DB_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                  found_q, found_d;
    logic                  overflow_q, overflow_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CODE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CODE_WIDTH-1:0] push_code;
    logic                  tick, any_low, push, pop, full, wr_en;

    function automatic logic [CODE_WIDTH-1:0] code_of(
        input logic [ROW_W-1:0] r,
        input logic [COL_W-1:0] c
    );
        return CODE_WIDTH'(r) * CODE_WIDTH'(NUM_COLS) + CODE_WIDTH'(c);
    endfunction

    always_comb begin
        tick     = (pre_q == PRE_W'(SCAN_DIVIDER - 1));
        pre_d    = tick ? '0 : pre_q + 1'b1;
        any_low  = ~&rows_sync_q;
        low_row  = '0;
        // Descending walk so the lowest-index low row wins.
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_sync_q[i]) low_row = ROW_W'(i);
        end
        col_next = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
        cnt_inc  = cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_code = code_of(row_q, col_q);
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_d = low_row;
                        cnt_d = DB_W'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            push      = 1'b1;
                            push_code = code_of(low_row, col_q);
                            cnt_d     = '0;
                            state_d   = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (!rows_sync_q[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_W'(DEBOUNCE_TICKS)) begin
                            push    = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_next;
                    end
                end
                HELD: begin
                    if (rows_sync_q[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_W'(DEBOUNCE_TICKS)) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                            col_d   = col_next;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        pop        = KeyRead && (count_q != '0);
        full       = (count_q == CNT_WIDTH'(FIFO_DEPTH));
        // A simultaneous pop frees a slot, so a full FIFO still accepts.
        wr_en      = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        found_d    = push;
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q     <= SCAN;
            rows_meta_q <= '1;
            rows_sync_q <= '1;
            pre_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rows_meta_q <= Rows;
            rows_sync_q <= rows_meta_q;
            pre_q       <= pre_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_code;
    end

    always_comb begin
        Columns        = '1;
        Columns[col_q] = 1'b0;
    end

    assign KeyValid = (count_q != '0);
    assign KeyCode  = KeyValid ? mem_q[rd_ptr_q] : '0;
    assign Count    = count_q;
    assign Found    = found_q;
    assign Locked   = (state_q == HELD);
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Bench for keypad_scanner_fifo: a keypad model drives Rows from Columns,
// expected key codes queue up at press time and are checked as they drain.
module tb_keypad_scanner_fifo;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int SD = 3;
    localparam int DB = 2;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_read = 1'b0;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] count;
    logic       found, locked, overflow;

    int checks = 0;
    int errors = 0;
    int found_cnt = 0;
    bit exp_ovf = 0;
    logic [3:0] sb [$];

    logic       ovr_en = 1'b0;
    logic [3:0] ovr_rows = 4'b1111;
    logic       key_down = 1'b0;
    logic [1:0] key_row = 2'd0;
    logic [1:0] key_col = 2'd0;

    keypad_scanner_fifo #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DIVIDER(SD),
        .DEBOUNCE_TICKS(DB), .FIFO_DEPTH(FD)
    ) dut (
        .ClockIn(clk), .Reset(rst), .Rows(rows), .Columns(cols),
        .KeyRead(key_read), .KeyValid(key_valid), .KeyCode(key_code),
        .Count(count), .Found(found), .Locked(locked), .Overflow(overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'b1111;
        if (ovr_en) rows = ovr_rows;
        else if (key_down && cols[key_col] == 1'b0) rows[key_row] = 1'b0;
    end

    always @(posedge clk) if (found) found_cnt <= found_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_col(input logic [1:0] c);
        logic [3:0] prev;
        bit ok;
        ok = 0;
        prev = cols;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cols[c] == 1'b0 && prev[c] == 1'b1) begin
                ok = 1;
                break;
            end
            prev = cols;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_col timeout: columns=%b wanted col %0d", cols, c);
        end
    endtask

    task automatic wait_unlock();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!locked) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL unlock timeout: locked=%b required 0", locked);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c, input bit rel);
        int lat;
        if (sb.size() < FD) sb.push_back({r, c});
        else exp_ovf = 1;
        wait_col(c);
        key_row = r; key_col = c; key_down = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (found) break;
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL press_latency key %0d: got %0d cycles, required 6", {r, c}, lat);
        end
        checks++;
        if (count !== 3'(sb.size()) || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL press_state: count=%0d ovf=%b, required count=%0d ovf=%b",
                     count, overflow, sb.size(), exp_ovf);
        end
        if (rel) begin
            key_down = 1'b0;
            wait_unlock();
        end
    endtask

    task automatic drain();
        logic [3:0] exp;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!key_valid) break;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL drain_extra: key_code=%0d with empty scoreboard", key_code);
            end else begin
                exp = sb.pop_front();
                if (key_code !== exp) begin
                    errors++;
                    $display("FAIL drain_code: got %0d, required %0d", key_code, exp);
                end
            end
            key_read = 1'b1;
            @(negedge clk);
            key_read = 1'b0;
        end
        checks++;
        if (key_valid !== 1'b0 || count !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b count=%0d, required 0/0 with %0d left",
                     key_valid, count, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 ||
            count !== 3'd0 || found !== 1'b0 || locked !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cols=%b v=%b code=%0d cnt=%0d f=%b l=%b o=%b, required 1110/0/0/0/0/0/0",
                     cols, key_valid, key_code, count, found, locked, overflow);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] seq [4];
        logic [3:0] prev;
        int n;
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
        prev = cols;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (cols === prev && n < 10);
            checks++;
            if (cols !== seq[k] || n != SD) begin
                errors++;
                $display("FAIL scan_step %0d: cols=%b after %0d clocks, required %b after %0d",
                         k, cols, n, seq[k], SD);
            end
            prev = cols;
        end
        checks++;
        if (key_valid !== 1'b0 || count !== 3'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL scan_idle: v=%b cnt=%0d l=%b, required 0/0/0", key_valid, count, locked);
        end
    endtask

    task automatic test_press_release();
        int f0;
        f0 = found_cnt;
        press(2'd2, 2'd1, 0);
        checks++;
        if (key_valid !== 1'b1 || key_code !== sb[0] || locked !== 1'b1 || cols !== 4'b1101) begin
            errors++;
            $display("FAIL press_head: v=%b code=%0d l=%b cols=%b, required 1/%0d/1/1101",
                     key_valid, key_code, locked, cols, sb[0]);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (found_cnt - f0 != 1 || cols !== 4'b1101 || locked !== 1'b1) begin
            errors++;
            $display("FAIL press_hold: founds=%0d cols=%b l=%b, required 1/1101/1",
                     found_cnt - f0, cols, locked);
        end
        key_down = 1'b0;
        wait_unlock();
        checks++;
        if (cols !== 4'b1011) begin
            errors++;
            $display("FAIL release_resume: cols=%b, required 1011", cols);
        end
        drain();
    endtask

    task automatic test_bounce_priority();
        int f0;
        f0 = found_cnt;
        wait_col(2'd2);
        ovr_en = 1'b1;
        ovr_rows = 4'b1011;
        repeat (3) @(negedge clk);
        ovr_rows = 4'b1111;
        repeat (30) @(negedge clk);
        checks++;
        if (found_cnt != f0 || count !== 3'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bounce: founds=%0d cnt=%0d l=%b, required 0/0/0",
                     found_cnt - f0, count, locked);
        end
        wait_col(2'd0);
        ovr_rows = 4'b0011;
        sb.push_back(4'd8);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (found) break;
        end
        checks++;
        if (found !== 1'b1 || key_code !== sb[0]) begin
            errors++;
            $display("FAIL row_priority: found=%b code=%0d, required 1/%0d", found, key_code, sb[0]);
        end
        ovr_rows = 4'b1111;
        wait_unlock();
        ovr_en = 1'b0;
        drain();
    endtask

    task automatic test_overflow();
        int f0;
        f0 = found_cnt;
        press(2'd0, 2'd0, 1);
        press(2'd1, 2'd1, 1);
        press(2'd2, 2'd2, 1);
        press(2'd3, 2'd3, 1);
        press(2'd0, 2'd3, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (found_cnt - f0 != 5 || count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: founds=%0d cnt=%0d ovf=%b, required 5/4/1",
                     found_cnt - f0, count, overflow);
        end
        drain();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_ovf = 0;
        press(2'd0, 2'd1, 1);
        press(2'd0, 2'd2, 1);
        press(2'd1, 2'd0, 1);
        press(2'd1, 2'd2, 1);
        wait_col(2'd3);
        key_row = 2'd1; key_col = 2'd3; key_down = 1'b1;
        repeat (5) @(negedge clk);
        exp = sb.pop_front();
        sb.push_back(4'd7);
        checks++;
        if (key_code !== exp || count !== 3'd4) begin
            errors++;
            $display("FAIL full_head: code=%0d cnt=%0d, required %0d/4", key_code, count, exp);
        end
        key_read = 1'b1;
        @(negedge clk);
        key_read = 1'b0;
        checks++;
        if (found !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: found=%b cnt=%0d ovf=%b, required 1/4/0",
                     found, count, overflow);
        end
        key_down = 1'b0;
        wait_unlock();
        drain();
    endtask

    task automatic test_reset_held();
        press(2'd0, 2'd0, 1);
        press(2'd1, 2'd1, 0);
        checks++;
        if (count !== 3'd2 || locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d l=%b, required 2/1", count, locked);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || key_valid !== 1'b0 || count !== 3'd0 ||
            cols !== 4'b1110 || overflow !== 1'b0 || found !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: l=%b v=%b cnt=%0d cols=%b o=%b f=%b, required 0/0/0/1110/0/0",
                     locked, key_valid, count, cols, overflow, found);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.push_back(4'd5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (found) break;
        end
        checks++;
        if (found !== 1'b1 || key_code !== sb[0] || count !== 3'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL redetect: f=%b code=%0d cnt=%0d l=%b, required 1/%0d/1/1",
                     found, key_code, count, locked, sb[0]);
        end
        key_down = 1'b0;
        wait_unlock();
        drain();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press_release();
        test_bounce_priority();
        test_overflow();
        test_full_push_pop();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
